imu_spi_reg_fetch: RTL and testbench
====================================

Name: imu_spi_reg_fetch

Overview:
- SPI master that reads one register from the VectorNav IMU per `start` pulse.
- Sits directly upstream of the IMU capture sequencer and feeds it. The sequencer issues register index, length and first word to keep; this block returns the kept words as 32-bit beats and then pulses `done`.
- Uses the two-transaction VectorNav read protocol:
  - request frame;
  - mandatory inter-frame wait;
  - response frame (4-byte header, then payload).

Parameters:
- SPEEDUP, 1: divides the inter-frame wait, for simulation. Must be ≥1.
- SPI_SCLK_DIV, 16: SCK half-period in `c` cycles, 8-bit. 16 gives ~3.9 MHz at 125 MHz. Must be ≥2.
- WAIT_CYCLES, 6250: inter-frame CS-high gap before division (50 µs at 125 MHz). Effective gap = WAIT_CYCLES/SPEEDUP, minimum 1.
- CS_GUARD, 8: `c` cycles between CS edge and the first/last SCK edge.

Ports:
- c  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only when busy=0
- reg_idx  in  8  register number; latched at start
- reg_len  in  8  payload words to clock out; latched
- reg_start_word  in  8  first payload word emitted; latched
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse, end of response frame
- err  out  1  valid with done: header mismatch
- err_code  out  8  valid with done: header byte 3 from IMU
- reg_d  out  32  payload word, first received byte in [31:24]
- reg_dv  out  1  one-cycle strobe for reg_d
- cs  out  1  active-low chip select
- sck  out  1  SPI clock, mode 3 (idle high)
- mosi  out  1  MSB first
- miso  in  1  sampled on SCK rising edge

Behaviour:
- Reset state: cs=1, sck=1, mosi=0, busy=0, done=0, err=0, err_code=0, reg_dv=0, reg_d=0, FSM=IDLE.
- Reset mid-frame aborts immediately. The frame is discarded and no `done` is emitted.
- SPI framing:
  - Mode 3. mosi changes on SCK falling edge and is sampled by the IMU on rising edge.
  - The first falling edge comes CS_GUARD cycles after cs falls.
  - cs rises CS_GUARD cycles after the last rising edge.
- FSM states and transitions:
  - IDLE: on start, latch idx/len/start_word and go to REQ.
  - REQ: cs low; shift out 4 bytes {0x01, idx, 0x00, 0x00}; go to GAP.
  - GAP: cs high for the effective wait; go to RSP_HDR.
  - RSP_HDR: cs low; shift 4 bytes out as 0x00 while capturing h0..h3; go to RSP_DATA.
  - RSP_DATA: 32·len bits, mosi=0; go to FIN.
  - FIN: cs high after CS_GUARD; go to END.
  - END: done=1 for one cycle; go to IDLE.
- Word output:
  - Payload word counter k runs 0..len-1.
  - After the 32nd rising-edge sample of word k: if k ≥ start_word, reg_dv=1 the following cycle with reg_d = assembled word. Otherwise the word is dropped.
- Width rule: word count, bit count and divider counters are 8, 5 and 8 bits. No wrap is permitted within a frame; the len=255 maximum fits.
- len=0: response frame carries the header only; no reg_dv; done still pulses.
- start_word ≥ len: full frame is clocked; zero reg_dv; done pulses.
- busy stays 0 in the END cycle. A start asserted in the same cycle as done is accepted; this is the back-to-back case the capture sequencer relies on.
- start while busy=1 is ignored. There is no queueing.
- Inputs idx/len/start_word may change freely after the start cycle.
- Total emitted reg_dv per transaction = max(0, len − start_word).

Optional Feature:
- Macro: IMU_SPI_HDR_CHECK_EN.
- Defined:
  - err = (h1≠0x01) | (h2≠idx) | (h3≠0x00); err_code=h3, both held from done until the next accepted start.
  - Payload is still streamed when err=1.
- Undefined: header bytes are clocked and discarded; err=0 and err_code=0 always.

Test Plan:
- idx=54, len=11, start_word=3, SPEEDUP=100, DIV=4: MOSI request bytes 0x01,0x36,0x00,0x00 → 8 reg_dv pulses carrying IMU-model words 3..10 → one done; cs high for ≥62 cycles between frames.
- idx=17, len=3, start=0, model payload 0x11223344, 0x55667788, 0x99AABBCC → reg_d in that order with byte 0x11 in [31:24]; done 1 cycle after last cs rise + guard.
- len=0, then start_word=5/len=4 → 0 reg_dv each; done asserted once per request; busy low afterwards.
- start in the same cycle as done, then again while busy → second request runs immediately; the busy-time start produces no extra frame.
- rst asserted mid-RSP_DATA → cs=1, sck=1 next cycle; no done; a new start then completes normally.
- IMU_SPI_HDR_CHECK_EN defined, model header h3=0x03 → done with err=1, err_code=0x03, payload still emitted; with the macro undefined → err=0.

Source files
------------

// File: rtl/imu_spi_reg_fetch.sv
// rtl/imu_spi_reg_fetch.sv - SPI mode-3 master reading one VectorNav register per start pulse
// Define IMU_SPI_HDR_CHECK_EN to compare the response header and report err/err_code.
module imu_spi_reg_fetch #(
  parameter int SPEEDUP      = 1,
  parameter int SPI_SCLK_DIV = 16,
  parameter int WAIT_CYCLES  = 6250,
  parameter int CS_GUARD     = 8
) (
  input  logic        c,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  reg_idx,
  input  logic [7:0]  reg_len,
  input  logic [7:0]  reg_start_word,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_code,
  output logic [31:0] reg_d,
  output logic        reg_dv,
  output logic        cs,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);
  localparam int GAP_EFF = ((WAIT_CYCLES / SPEEDUP) < 1) ? 1 : (WAIT_CYCLES / SPEEDUP);
  localparam int GW = $clog2(GAP_EFF + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_EFF - 1);
  localparam logic [7:0] DIV_LAST = 8'(SPI_SCLK_DIV - 1);
  localparam logic [7:0] GUARD_LAST = 8'(CS_GUARD - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_RSP_HDR, S_RSP_DATA, S_FIN, S_END} state_t;
  typedef enum logic [1:0] {PH_LEAD, PH_SHIFT, PH_TRAIL} phase_t;

  state_t state, nxt;
  phase_t ph;
  logic [7:0]    div_cnt, word_cnt, len_q, sw_q;
  logic [4:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   tx_sr, rx_word;
  logic [30:0]   rx_sr;
  logic          framing, accept, wrap, rise, fall, last_bit;

  // Every framed state shares one divider that wraps at the guard length or the half-period.
  assign framing  = (state == S_REQ) || (state == S_RSP_HDR) || (state == S_RSP_DATA) || (state == S_FIN);
  assign accept   = start && ((state == S_IDLE) || (state == S_END));
  assign wrap     = (div_cnt == ((ph == PH_SHIFT) ? DIV_LAST : GUARD_LAST));
  assign rise     = framing && (ph == PH_SHIFT) && !sck && wrap;
  assign fall     = framing && (ph == PH_SHIFT) && sck && wrap;
  assign last_bit = (bit_cnt == 5'd31);
  assign rx_word  = {rx_sr, miso};

  always_ff @(posedge c) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     if (start) nxt = S_REQ;
      S_REQ:      if ((ph == PH_TRAIL) && wrap) nxt = S_GAP;
      S_GAP:      if (gap_cnt == GAP_LAST) nxt = S_RSP_HDR;
      S_RSP_HDR:  if (rise && last_bit) nxt = (len_q == 8'd0) ? S_FIN : S_RSP_DATA;
      S_RSP_DATA: if (rise && last_bit && (word_cnt == len_q - 8'd1)) nxt = S_FIN;
      S_FIN:      if (wrap) nxt = S_END;
      S_END:      nxt = start ? S_REQ : S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cs   = !framing;
    busy = framing || (state == S_GAP);
    done = (state == S_END);
  end

  always_ff @(posedge c) begin
    if (rst) begin
      ph       <= PH_LEAD;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      gap_cnt  <= '0;
      len_q    <= '0;
      sw_q     <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sck      <= 1'b1;
      mosi     <= 1'b0;
      reg_dv   <= 1'b0;
      reg_d    <= '0;
    end else begin
      reg_dv  <= 1'b0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (accept) begin
        len_q <= reg_len;
        sw_q  <= reg_start_word;
        tx_sr <= {8'h01, reg_idx, 16'h0000};
      end
      if (!framing || wrap) div_cnt <= '0;
      else                  div_cnt <= div_cnt + 8'd1;
      if (!framing)                               ph <= PH_LEAD;
      else if ((ph == PH_LEAD) && wrap)           ph <= PH_SHIFT;
      else if (rise && last_bit && ((state == S_REQ) || (nxt == S_FIN))) ph <= PH_TRAIL;
      if ((framing && (ph == PH_LEAD) && wrap) || fall) begin
        sck <= 1'b0;
        if (state == S_REQ) begin
          mosi  <= tx_sr[31];
          tx_sr <= {tx_sr[30:0], 1'b0};
        end else begin
          mosi <= 1'b0;
        end
      end
      if (!framing) bit_cnt <= '0;
      else if (rise) begin
        sck     <= 1'b1;
        rx_sr   <= rx_word[30:0];
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (state != S_RSP_DATA)        word_cnt <= '0;
      else if (rise && last_bit)      word_cnt <= word_cnt + 8'd1;
      if ((state == S_RSP_DATA) && rise && last_bit && (word_cnt >= sw_q)) begin
        reg_dv <= 1'b1;
        reg_d  <= rx_word;
      end
    end
  end

`ifdef IMU_SPI_HDR_CHECK_EN
  logic [23:0] hdr;
  logic [7:0]  idx_q;

  // Result is held from done until the next accepted start clears it.
  always_ff @(posedge c) begin
    if (rst) begin
      hdr      <= '0;
      idx_q    <= '0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      if ((state == S_RSP_HDR) && rise && last_bit) hdr <= rx_word[23:0];
      if (accept) begin
        idx_q    <= reg_idx;
        err      <= 1'b0;
        err_code <= '0;
      end else if ((state == S_FIN) && wrap) begin
        err      <= (hdr[23:16] != 8'h01) || (hdr[15:8] != idx_q) || (hdr[7:0] != 8'h00);
        err_code <= hdr[7:0];
      end
    end
  end
`else
  assign err      = 1'b0;
  assign err_code = 8'h00;
`endif
endmodule

// File: tb/tb_imu_spi_reg_fetch.sv
// tb/tb_imu_spi_reg_fetch.sv - randomized self-checking bench with behavioural IMU slave model
module tb_imu_spi_reg_fetch;
  localparam int DIV     = 4;
  localparam int GUARD   = 8;
  localparam int SPEEDUP = 100;
  localparam int WAIT    = 6250;
  localparam int GAP_EFF = WAIT / SPEEDUP;

  logic        c = 1'b0, rst = 1'b1, start = 1'b0, miso = 1'b0;
  logic [7:0]  reg_idx = '0, reg_len = '0, reg_start_word = '0;
  logic        busy, done, err, reg_dv, cs, sck, mosi;
  logic [7:0]  err_code;
  logic [31:0] reg_d;

  always #5 c = ~c;

  imu_spi_reg_fetch #(.SPEEDUP(SPEEDUP), .SPI_SCLK_DIV(DIV), .WAIT_CYCLES(WAIT), .CS_GUARD(GUARD)) dut (
    .c(c), .rst(rst), .start(start), .reg_idx(reg_idx), .reg_len(reg_len),
    .reg_start_word(reg_start_word), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .reg_d(reg_d), .reg_dv(reg_dv), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso)
  );

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // IMU model and transaction expectations
  logic [31:0] words [256];
  logic [31:0] exp_q [$];
  logic [31:0] req_bits;
  logic [7:0]  exp_idx, got_idx, m_h3;
  int exp_len, exp_sw, d_start;
  int cyc = 0, done_cnt = 0, dv_cnt = 0, cs_fall_cnt = 0;
  int req_cnt = 0, rsp_cnt = 0, mosi_ones = 0;
  int fall_cyc = 0, cs_rise_cyc = 0, last_rise_cyc = 0;
  bit expect_req = 1'b1, first_fall = 1'b0;

  function automatic logic rsp_bit(input int n);
    logic [31:0] hdr, w;
    int k;
    hdr = {8'h00, 8'h01, got_idx, m_h3};
    if (n < 32) return hdr[31-n];
    k = (n - 32) / 32;
    if (k > 255) k = 255;
    w = words[k];
    return w[31 - ((n - 32) % 32)];
  endfunction

  function automatic logic [31:0] exp_err();
`ifdef IMU_SPI_HDR_CHECK_EN
    return (m_h3 != 8'h00) ? 32'd1 : 32'd0;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_code();
`ifdef IMU_SPI_HDR_CHECK_EN
    return {24'h0, m_h3};
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge c) cyc++;

  always @(negedge cs) if (!rst) begin
    cs_fall_cnt++;
    fall_cyc = cyc; first_fall = 1'b1;
    req_cnt = 0; rsp_cnt = 0; mosi_ones = 0; req_bits = '0;
    if (!expect_req) chk("gap_len", (cyc - cs_rise_cyc >= GAP_EFF) ? 32'd1 : 32'd0, 32'd1);
  end

  always @(negedge sck) if (!rst && !cs) begin
    if (first_fall) begin
      chk("lead_guard", cyc - fall_cyc, GUARD);
      first_fall = 1'b0;
    end
    if (!expect_req) miso = rsp_bit(rsp_cnt);
  end

  always @(posedge sck) if (!rst && !cs) begin
    last_rise_cyc = cyc;
    if (expect_req) begin
      req_bits = {req_bits[30:0], mosi};
      req_cnt++;
    end else begin
      rsp_cnt++;
      if (mosi) mosi_ones++;
    end
  end

  always @(posedge cs) if (!rst) begin
    cs_rise_cyc = cyc;
    chk("trail_guard", cyc - last_rise_cyc, GUARD);
    if (expect_req) begin
      chk("req_bits", req_cnt, 32);
      chk("req_word", req_bits, {8'h01, exp_idx, 16'h0000});
      got_idx = req_bits[23:16];
    end else begin
      chk("rsp_bits", rsp_cnt, 32 * (exp_len + 1));
      chk("rsp_mosi_zero", mosi_ones, 0);
    end
    expect_req = !expect_req;
  end

  always @(negedge c) begin
    if (done) done_cnt++;
    if (reg_dv) begin
      dv_cnt++;
      if (exp_q.size() > 0) chk("reg_d", reg_d, exp_q.pop_front());
    end
  end

  task automatic prep(input logic [7:0] idx, input int len, input int sw, input logic [7:0] h3);
    exp_idx = idx; exp_len = len; exp_sw = sw; m_h3 = h3;
    for (int k = 0; k < 256; k++) words[k] = $urandom;
  endtask

  task automatic arm();
    exp_q.delete();
    dv_cnt = 0;
    for (int k = exp_sw; k < exp_len; k++) exp_q.push_back(words[k]);
  endtask

  // Called at a negedge; leaves the bench one negedge later with start released.
  task automatic issue();
    reg_idx = exp_idx; reg_len = 8'(exp_len); reg_start_word = 8'(exp_sw); start = 1'b1;
    @(negedge c);
    start = 1'b0;
    reg_idx = 8'($urandom); reg_len = 8'($urandom); reg_start_word = 8'($urandom);
    d_start = done_cnt;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge c);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_dv_count"}, dv_cnt, (exp_len > exp_sw) ? exp_len - exp_sw : 0);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_err"}, err, exp_err());
    chk({tag, "_err_code"}, err_code, exp_code());
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_done_vs_cs"}, (cyc - cs_rise_cyc <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic finish_txn(input string tag);
    @(negedge c);
    chk({tag, "_done_pulses"}, done_cnt - d_start, 1);
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_err_hold"}, err, exp_err());
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, d0, csf, len, sw;
    logic [7:0] h3;
    repeat (3) @(negedge c);
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_reg_dv", reg_dv, 0);
    chk("rst_reg_d", reg_d, 0);
    rst = 1'b0;
    @(negedge c);

    prep(8'd54, 11, 3, 8'h00); arm(); issue(); wait_done("idx54"); finish_txn("idx54");

    @(negedge c);
    prep(8'd17, 3, 0, 8'h00);
    words[0] = 32'h1122_3344; words[1] = 32'h5566_7788; words[2] = 32'h99AA_BBCC;
    arm(); issue(); wait_done("idx17"); finish_txn("idx17");

    @(negedge c); prep(8'h20, 0, 0, 8'h00); arm(); issue(); wait_done("len0"); finish_txn("len0");
    @(negedge c); prep(8'h21, 4, 5, 8'h00); arm(); issue(); wait_done("sw_ge_len"); finish_txn("sw_ge_len");

    @(negedge c); prep(8'h05, 2, 0, 8'h00); arm(); issue(); wait_done("b2b_a");
    prep(8'h06, 2, 1, 8'h00); arm(); issue();
    repeat (20) @(negedge c);
    reg_idx = 8'd99; reg_len = 8'd1; reg_start_word = 8'd0; start = 1'b1;
    @(negedge c);
    start = 1'b0;
    wait_done("b2b_b"); finish_txn("b2b_b");
    csf = cs_fall_cnt;
    repeat (400) @(negedge c);
    chk("b2b_no_extra_frame", cs_fall_cnt - csf, 0);
    chk("b2b_busy_low", busy, 0);

    @(negedge c); prep(8'h09, 6, 0, 8'h00); arm(); issue();
    n = 0;
    while (!(!expect_req && rsp_cnt >= 64) && n < 20000) begin
      @(negedge c);
      n++;
    end
    chk("rst_reached_data", (n < 20000) ? 32'd1 : 32'd0, 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge c);
    chk("midrst_cs", cs, 1);
    chk("midrst_sck", sck, 1);
    chk("midrst_busy", busy, 0);
    rst = 1'b0; exp_q.delete(); dv_cnt = 0; expect_req = 1'b1;
    repeat (50) @(negedge c);
    chk("midrst_no_done", done_cnt - d0, 0);
    prep(8'h0A, 3, 1, 8'h00); arm(); issue(); wait_done("after_rst"); finish_txn("after_rst");

    @(negedge c); prep(8'd54, 2, 0, 8'h03); arm(); issue(); wait_done("hdr_err"); finish_txn("hdr_err");

    for (int t = 0; t < 5; t++) begin
      len = $urandom_range(0, 12);
      sw  = $urandom_range(0, len + 2);
      h3  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      @(negedge c);
      prep(8'($urandom), len, sw, h3); arm(); issue(); wait_done("rand"); finish_txn("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
